// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter
// ---------------------------------------------------------------------------
// Shares the single register-file write port between three result sources:
// EX (single-cycle ALU/CSR), LSU (load returns, through a one-entry skid
// buffer) and MD (multiply/divide completion). It also keeps a scoreboard of
// destination registers with multicycle results still in flight, so that the
// ID stage can stall on RAW/WAW hazards.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   issue_valid_i/rd_i/is_load_i       multicycle issue, sets scoreboard
//   flush_i                            kills pending non-load results
//   raddr_a_i/raddr_b_i                ID source registers
//   hazard_a_o/hazard_b_o/hazard_waw_o combinational scoreboard lookups
//   ex_*  / lsu_* / md_*               result sources (valid/ready)
//   rf_we_o/rf_waddr_o/rf_wdata_o      registered register-file write port
//   busy_o                             any result pending or skid occupied
//
// Handshake semantics (all three sources): a source raises valid with rd and
// wdata and holds all of them stable until the cycle in which its ready is
// also high; that cycle is the transfer. Ready may depend combinationally on
// valid (EX/MD ready is the grant), but valid never depends on ready.
// ---------------------------------------------------------------------------
module ibex_wb_arbiter #(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned MD_MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_is_load_i,
  input  logic        flush_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic        hazard_a_o,
  output logic        hazard_b_o,
  output logic        hazard_waw_o,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [31:0] ex_wdata_i,
  output logic        ex_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_err_i,
  output logic        lsu_ready_o,
  input  logic        md_valid_i,
  input  logic [4:0]  md_rd_i,
  input  logic [31:0] md_wdata_i,
  output logic        md_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        busy_o
);

  localparam logic [3:0] MaxWait = 4'(MD_MAX_WAIT);

  // Scoreboard and load mask
  logic [31:0] pend_q, pend_ld_q;
  logic [31:0] pend_d, pend_ld_d;

  // Skid buffer
  logic        skid_full_q;
  logic [4:0]  skid_rd_q;
  logic [31:0] skid_wdata_q;
  logic        skid_err_q;

  // Starvation counter
  logic [3:0]  md_wait_q;

  // Write port registers; wb_clr_q marks a committed LSU/MD write whose
  // scoreboard bit is cleared on the following edge.
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        wb_clr_q;

  // Load source selection
  logic        l_valid;
  logic [4:0]  l_rd;
  logic [31:0] l_wdata;
  logic        l_err;

  logic        md_starve;
  logic        gnt_ex, gnt_l, gnt_md, gnt_any;
  logic [4:0]  win_rd;
  logic [31:0] win_wdata;
  logic        win_err;
  logic        we_d;
  logic        set_en;
  logic [31:0] set_vec, clr_vec;

  function automatic logic rd_in_range(input logic [4:0] rd);
    return !(RV32E && rd[4]);
  endfunction

  assign lsu_ready_o = !skid_full_q;

  // The skid entry is always older than any live beat, so it goes first.
  assign l_valid = skid_full_q | lsu_valid_i;
  assign l_rd    = skid_full_q ? skid_rd_q    : lsu_rd_i;
  assign l_wdata = skid_full_q ? skid_wdata_q : lsu_wdata_i;
  assign l_err   = skid_full_q ? skid_err_q   : lsu_err_i;

  assign md_starve = md_valid_i && (md_wait_q == MaxWait);

  always_comb begin
    gnt_ex = 1'b0;
    gnt_l  = 1'b0;
    gnt_md = 1'b0;
    if (md_starve)        gnt_md = 1'b1;
    else if (ex_valid_i)  gnt_ex = 1'b1;
    else if (l_valid)     gnt_l  = 1'b1;
    else if (md_valid_i)  gnt_md = 1'b1;
  end

  assign gnt_any    = gnt_ex | gnt_l | gnt_md;
  assign ex_ready_o = gnt_ex;
  assign md_ready_o = gnt_md;

  always_comb begin
    win_rd    = 5'd0;
    win_wdata = 32'd0;
    win_err   = 1'b0;
    if (gnt_ex) begin
      win_rd    = ex_rd_i;
      win_wdata = ex_wdata_i;
    end else if (gnt_l) begin
      win_rd    = l_rd;
      win_wdata = l_wdata;
      win_err   = l_err;
    end else if (gnt_md) begin
      win_rd    = md_rd_i;
      win_wdata = md_wdata_i;
    end
  end

  assign we_d = gnt_any && (win_rd != 5'd0) && !win_err && rd_in_range(win_rd);

  // Scoreboard next state: clear, then flush, then set (set wins).
  assign set_en  = issue_valid_i && !flush_i && (issue_rd_i != 5'd0) &&
                   rd_in_range(issue_rd_i);
  assign set_vec = set_en ? (32'd1 << issue_rd_i) : 32'd0;

  always_comb begin
    clr_vec = 32'd0;
    if (wb_clr_q)        clr_vec = clr_vec | (32'd1 << rf_waddr_q);
    if (gnt_l && l_err)  clr_vec = clr_vec | (32'd1 << l_rd);
  end

  always_comb begin
    pend_d = pend_q & ~clr_vec;
    if (flush_i) pend_d = pend_d & pend_ld_q;
    pend_d = pend_d | set_vec;

    pend_ld_d = pend_ld_q & ~clr_vec;
    if (set_en) pend_ld_d[issue_rd_i] = issue_is_load_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q       <= 32'd0;
      pend_ld_q    <= 32'd0;
      skid_full_q  <= 1'b0;
      skid_rd_q    <= 5'd0;
      skid_wdata_q <= 32'd0;
      skid_err_q   <= 1'b0;
      md_wait_q    <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      wb_clr_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pend_ld_q <= pend_ld_d;

      // While full, lsu_ready_o is low, so no live beat can arrive.
      if (skid_full_q) begin
        if (gnt_l) skid_full_q <= 1'b0;
      end else if (lsu_valid_i && !gnt_l) begin
        skid_full_q  <= 1'b1;
        skid_rd_q    <= lsu_rd_i;
        skid_wdata_q <= lsu_wdata_i;
        skid_err_q   <= lsu_err_i;
      end

      if (!md_valid_i || gnt_md)  md_wait_q <= 4'd0;
      else if (md_wait_q != MaxWait) md_wait_q <= md_wait_q + 4'd1;

      rf_we_q  <= we_d;
      wb_clr_q <= we_d && (gnt_l || gnt_md);
      if (we_d) begin
        rf_waddr_q <= win_rd;
        rf_wdata_q <= win_wdata;
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

  assign hazard_a_o   = (raddr_a_i  != 5'd0) && pend_q[raddr_a_i];
  assign hazard_b_o   = (raddr_b_i  != 5'd0) && pend_q[raddr_b_i];
  assign hazard_waw_o = (issue_rd_i != 5'd0) && pend_q[issue_rd_i];

  assign busy_o = (|pend_q) | skid_full_q;

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Directed bench for ibex_wb_arbiter (RV32E=0, MD_MAX_WAIT=4).
module tb_ibex_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_is_load = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic        hazard_a, hazard_b, hazard_waw;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_wdata = '0;
  logic        ex_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_err = 1'b0;
  logic        lsu_ready;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_wdata = '0;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset
  always #5 clk = ~clk;

  ibex_wb_arbiter #(.RV32E(1'b0), .MD_MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .issue_is_load_i(issue_is_load), .flush_i(flush),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(hazard_a), .hazard_b_o(hazard_b), .hazard_waw_o(hazard_waw),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_wdata_i(ex_wdata),
    .ex_ready_o(ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
    .lsu_err_i(lsu_err), .lsu_ready_o(lsu_ready),
    .md_valid_i(md_valid), .md_rd_i(md_rd), .md_wdata_i(md_wdata),
    .md_ready_o(md_ready),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .busy_o(busy)
  );

  // Advance one edge, then settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; issue_is_load = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; lsu_valid = 1'b0; lsu_err = 1'b0; md_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL reset_we got %b exp 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0)  begin n_fail++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lsu_ready got %b exp 1", lsu_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_basic();
    raddr_a = 5'd5;
    issue_valid = 1'b1; issue_rd = 5'd5; issue_is_load = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL ld_hazard_set got %b exp 1", hazard_a); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL ld_busy_set got %b exp 1", busy); end
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL ld_lsu_ready got %b exp 1", lsu_ready); end
    tick();
    lsu_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1)           begin n_fail++; $display("FAIL ld_we got %b exp 1", rf_we); end
    n_checks++; if (rf_waddr !== 5'd5)        begin n_fail++; $display("FAIL ld_waddr got %0d exp 5", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_wdata got %h exp deadbeef", rf_wdata); end
    n_checks++; if (hazard_a !== 1'b1)        begin n_fail++; $display("FAIL ld_hazard_g1 got %b exp 1", hazard_a); end
    tick();
    n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL ld_we_g2 got %b exp 0", rf_we); end
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL ld_hazard_g2 got %b exp 0", hazard_a); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL ld_busy_g2 got %b exp 0", busy); end
  endtask

  task automatic test_skid();
    ex_valid = 1'b1; ex_rd = 5'd3; ex_wdata = 32'h0000_0033;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'h0000_0077;
    #1;
    n_checks++; if (ex_ready !== 1'b1)  begin n_fail++; $display("FAIL skid_ex_ready got %b exp 1", ex_ready); end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL skid_lsu_ready0 got %b exp 1", lsu_ready); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33)
      begin n_fail++; $display("FAIL skid_ex_write got we=%b a=%0d d=%h exp 1/3/33", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL skid_lsu_ready1 got %b exp 0", lsu_ready); end
    n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL skid_busy got %b exp 1", busy); end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77)
      begin n_fail++; $display("FAIL skid_ld_write got we=%b a=%0d d=%h exp 1/7/77", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL skid_lsu_ready2 got %b exp 1", lsu_ready); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL skid_idle_we got %b exp 0", rf_we); end
  endtask

  task automatic test_md_starve();
    raddr_b = 5'd12;
    issue_valid = 1'b1; issue_rd = 5'd12; issue_is_load = 1'b0;
    tick();
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd12; md_wdata = 32'h0000_00C0;
    ex_valid = 1'b1; ex_rd = 5'd2;
    for (int c = 1; c <= 4; c++) begin
      ex_wdata = 32'(c);
      #1;
      n_checks++; if (md_ready !== 1'b0 || ex_ready !== 1'b1)
        begin n_fail++; $display("FAIL md_lose_c%0d got md=%b ex=%b exp 0/1", c, md_ready, ex_ready); end
      tick();
    end
    ex_wdata = 32'd5;
    #1;
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL md_win got %b exp 1", md_ready); end
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL md_ex_stall got %b exp 0", ex_ready); end
    tick();
    md_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0)
      begin n_fail++; $display("FAIL md_write got we=%b a=%0d d=%h exp 1/12/c0", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (hazard_b !== 1'b1) begin n_fail++; $display("FAIL md_hazard_g1 got %b exp 1", hazard_b); end
    #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL md_ex_resume got %b exp 1", ex_ready); end
    tick();
    ex_valid = 1'b0;
    n_checks++; if (rf_waddr !== 5'd2 || rf_wdata !== 32'd5)
      begin n_fail++; $display("FAIL md_ex_after got a=%0d d=%h exp 2/5", rf_waddr, rf_wdata); end
    n_checks++; if (hazard_b !== 1'b0) begin n_fail++; $display("FAIL md_hazard_g2 got %b exp 0", hazard_b); end
    tick();
  endtask

  task automatic test_flush();
    raddr_a = 5'd9; raddr_b = 5'd10;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_is_load = 1'b0;
    tick();
    issue_rd = 5'd10; issue_is_load = 1'b1;
    tick();
    issue_rd = 5'd11; issue_is_load = 1'b0; flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL flush_md_killed got %b exp 0", hazard_a); end
    n_checks++; if (hazard_b !== 1'b1) begin n_fail++; $display("FAIL flush_ld_kept got %b exp 1", hazard_b); end
    raddr_a = 5'd11;
    #1;
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL flush_issue_ignored got %b exp 0", hazard_a); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL flush_busy got %b exp 1", busy); end
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wdata = 32'h1010_1010;
    tick();
    lsu_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_g1 got %b exp 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_g2 got %b exp 0", busy); end
  endtask

  task automatic test_zero_err();
    ex_valid = 1'b1; ex_rd = 5'd0; ex_wdata = 32'hFFFF_FFFF;
    tick();
    ex_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got %b exp 0", rf_we); end
    raddr_a = 5'd4;
    issue_valid = 1'b1; issue_rd = 5'd4; issue_is_load = 1'b1;
    tick();
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wdata = 32'h4444_4444; lsu_err = 1'b1;
    #1;
    n_checks++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL err_hazard_pre got %b exp 1", hazard_a); end
    tick();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL err_we got %b exp 0", rf_we); end
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL err_hazard_clr got %b exp 0", hazard_a); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL err_busy got %b exp 0", busy); end
    tick();
  endtask

  task automatic test_waw_reset();
    raddr_a = 5'd6;
    issue_valid = 1'b1; issue_rd = 5'd6; issue_is_load = 1'b0;
    tick();
    #1;
    n_checks++; if (hazard_waw !== 1'b1) begin n_fail++; $display("FAIL waw_set got %b exp 1", hazard_waw); end
    issue_rd = 5'd0;
    #1;
    n_checks++; if (hazard_waw !== 1'b0) begin n_fail++; $display("FAIL waw_x0 got %b exp 0", hazard_waw); end
    idle_inputs();
    ex_valid = 1'b1; ex_rd = 5'd3; ex_wdata = 32'h3;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'h7;
    tick();
    lsu_valid = 1'b0;
    ex_rd = 5'd8; ex_wdata = 32'h8;
    tick();
    #1;
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_skid_full got %b exp 0", lsu_ready); end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      begin n_fail++; $display("FAIL rst_rf got we=%b a=%0d d=%h exp 0/0/0", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_skid_empty got %b exp 1", lsu_ready); end
    n_checks++; if (hazard_a !== 1'b0)  begin n_fail++; $display("FAIL rst_hazard got %b exp 0", hazard_a); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_skid();
    test_md_starve();
    test_flush();
    test_zero_err();
    test_waw_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
